// File: rtl/alu_muldiv_seq_if.sv
// Handshake and operand/result bundle between the 8051 sequencer and the
// iterative MUL/DIV engine.
interface alu_muldiv_seq_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic              op;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              ov_out;
    logic              cy_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, a_out, b_out, ov_out, cy_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, a_out, b_out, ov_out, cy_out
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative 8051 MUL AB / DIV AB engine: shift-add multiply, restoring divide.
// Define MULDIV_RADIX4_EN to retire two radix-2 steps per CALC cycle.
module alu_muldiv_seq #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_muldiv_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // acc holds the product (MUL) or {remainder, quotient} (DIV); opa/opb are
    // the shifting operand copies.
    typedef struct packed {
        logic [2*DATA_W-1:0] acc;
        logic [DATA_W-1:0]   opa;
        logic [DATA_W-1:0]   opb;
    } dp_t;

`ifdef MULDIV_RADIX4_EN
    localparam logic [2:0] LAST_CNT = 3'd3;
`else
    localparam logic [2:0] LAST_CNT = 3'd7;
`endif

    // One radix-2 iteration of either operation.
    function automatic dp_t step(input logic is_div, input dp_t cur);
        dp_t               nxt;
        logic [DATA_W:0]   sum;
        logic [DATA_W:0]   rem;
        logic [DATA_W-1:0] diff;
        nxt  = cur;
        sum  = {(DATA_W+1){1'b0}};
        rem  = {(DATA_W+1){1'b0}};
        diff = {DATA_W{1'b0}};
        if (!is_div) begin
            sum     = {1'b0, cur.acc[2*DATA_W-1:DATA_W]}
                    + (cur.opb[0] ? {1'b0, cur.opa} : {(DATA_W+1){1'b0}});
            nxt.acc = {sum, cur.acc[DATA_W-1:1]};
            nxt.opb = {1'b0, cur.opb[DATA_W-1:1]};
        end else begin
            rem = {cur.acc[2*DATA_W-1:DATA_W], cur.opa[DATA_W-1]};
            // Remainder stays below 2*divisor, so the low byte of the
            // difference is exact once the 9-bit compare has passed.
            if (rem >= {1'b0, cur.opb}) begin
                diff    = rem[DATA_W-1:0] - cur.opb;
                nxt.acc = {diff, cur.acc[DATA_W-2:0], 1'b1};
            end else begin
                nxt.acc = {rem[DATA_W-1:0], cur.acc[DATA_W-2:0], 1'b0};
            end
            nxt.opa = {cur.opa[DATA_W-2:0], 1'b0};
        end
        return nxt;
    endfunction

    state_t            state_q, state_d;
    logic              op_q, op_d;
    dp_t               dp_q, dp_d;
    dp_t               dp_step_s;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_out_q, a_out_d;
    logic [DATA_W-1:0] b_out_q, b_out_d;
    logic              ov_q, ov_d;
    logic              cy_q, cy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Datapath work retired in one CALC cycle.
    always_comb begin
`ifdef MULDIV_RADIX4_EN
        dp_step_s = step(op_q, step(op_q, dp_q));
`else
        dp_step_s = step(op_q, dp_q);
`endif
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dp_d    = dp_q;
        cnt_d   = cnt_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        ov_d    = ov_q;
        cy_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    dp_d  = '{acc: {(2*DATA_W){1'b0}}, opa: bus.a_in, opb: bus.b_in};
                    cnt_d = 3'd0;
                    if (bus.op && (bus.b_in == {DATA_W{1'b0}})) begin
                        state_d = S_DONE;
                        a_out_d = {DATA_W{1'b1}};
                        b_out_d = bus.a_in;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                dp_d  = dp_step_s;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    a_out_d = dp_step_s.acc[DATA_W-1:0];
                    b_out_d = dp_step_s.acc[2*DATA_W-1:DATA_W];
                    ov_d    = op_q ? 1'b0 : (dp_step_s.acc[2*DATA_W-1:DATA_W] != {DATA_W{1'b0}});
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            dp_q    <= '{acc: {(2*DATA_W){1'b0}}, opa: {DATA_W{1'b0}}, opb: {DATA_W{1'b0}}};
            cnt_q   <= 3'd0;
            a_out_q <= {DATA_W{1'b0}};
            b_out_q <= {DATA_W{1'b0}};
            ov_q    <= 1'b0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dp_q    <= dp_d;
            cnt_q   <= cnt_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            ov_q    <= ov_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.a_out  = a_out_q;
    assign bus.b_out  = b_out_q;
    assign bus.ov_out = ov_q;
    assign bus.cy_out = cy_q;

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative 8-bit multiply/divide engine for the 8051 core. Executes MUL AB and DIV AB over several cycles instead of through a single-cycle combinational multiplier/divider.
- The instruction sequencer issues operands with a start pulse and waits for done.
- Results return on the A/B writeback path with OV/CY flags for the PSW update logic.
- Full 8051 semantics: remainder returned, OV on overflow or divide-by-zero, CY always cleared.

Parameters:
- DATA_W, 8, operand width; only 8 is supported, kept for readability of width expressions.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- op  input  1  0 = MUL, 1 = DIV
- a_in  input  8  accumulator operand (multiplicand / dividend)
- b_in  input  8  B register operand (multiplier / divisor)
- busy  output  1  high from the cycle after start is accepted until done deasserts
- done  output  1  single-cycle pulse; results valid in this cycle and held afterwards
- a_out  output  8  MUL: product[7:0]; DIV: quotient
- b_out  output  8  MUL: product[15:8]; DIV: remainder
- ov_out  output  1  MUL: product > 8'hFF; DIV: divisor was zero
- cy_out  output  1  always 0 when done (8051 clears CY for MUL/DIV)

Behaviour:
- Reset (async, rst_n low): state = IDLE, busy = 0, done = 0, a_out = b_out = 8'h00, ov_out = cy_out = 0, iteration counter = 0. Reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE: on start = 1, latch op, a_in and b_in into internal operand registers and clear the 16-bit accumulator and counter.
  - DIV with b_in = 0: go directly to DONE.
  - Otherwise: go to CALC.
- CALC: one radix-2 step per cycle; counter increments 0..7; after the step with counter = 7, go to DONE. Exactly 8 CALC cycles.
  - MUL step: shift-add. If the multiplier LSB = 1, add the multiplicand into the upper half of the 16-bit product register (9-bit add keeps the carry), then shift the product right by 1.
  - DIV step: restoring division. Shift {remainder, dividend} left by 1. If remainder >= divisor, subtract and set quotient bit = 1, else 0.
- DONE: lasts one cycle, then returns to IDLE.
  - Registered outputs load on entry to DONE; done = 1 for that cycle only.
  - MUL: ov_out = (product[15:8] != 0).
  - DIV: ov_out = 0.
  - DIV by zero: a_out = 8'hFF, b_out = latched a_in, ov_out = 1.
  - cy_out = 0 in all cases.
- Latency, with start sampled at clock edge k:
  - Normal: done high after edge k+9; busy high after edges k+1 through k+9.
  - DIV by zero: done after edge k+1.
- busy is high in CALC and DONE states.
- start while not in IDLE (CALC or DONE) is ignored; no queueing. start is level-sampled: if held high, a new operation begins in the IDLE cycle after DONE.
- Operand inputs are don't-care after the accept cycle.
- a_out, b_out, ov_out and cy_out hold their last values until the next DONE or reset.
- All arithmetic is unsigned. Internal adders/subtractors are 9 bits wide so no carry is lost.

Optional Feature:
- Macro MULDIV_RADIX4_EN.
- Defined: two radix-2 steps per CALC cycle (chained combinationally); CALC lasts 4 cycles; normal done after edge k+5.
- Undefined: 8 CALC cycles as above.
- Results, flags, divide-by-zero latency and all handshake rules are identical in both builds.

Test Plan:
- MUL a_in=0x50, b_in=0xA0 -> done at k+9 (k+5 with radix-4); a_out=0x00, b_out=0x32, ov_out=1, cy_out=0.
- MUL 0x0F×0x10 -> a_out=0xF0, b_out=0x00, ov_out=0. Also MUL 0xFF×0xFF -> a_out=0x01, b_out=0xFE, ov_out=1.
- DIV 0xFB/0x12 -> a_out=0x0D, b_out=0x11, ov_out=0, cy_out=0. Also DIV 0x07/0x09 -> a_out=0x00, b_out=0x07.
- DIV 0x37/0x00 -> done at k+1; a_out=0xFF, b_out=0x37, ov_out=1, cy_out=0.
- Start MUL 0x03×0x04, pulse start with DIV operands at k+3 -> second request ignored; single done at k+9 with a_out=0x0C, b_out=0x00; start held high continuously -> back-to-back ops, done pulses 10 cycles apart.
- Assert rst_n=0 at k+4 of a DIV -> all outputs 0 at once, busy=0, no done pulse; next start after release completes normally.
